// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU post-commit store path.
package lsu_pkg;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   // Widest byte address the entry format can hold; word address drops [1:0]
   localparam int LSU_ADDR_W = 32;
   localparam int LSU_WA_W   = LSU_ADDR_W - 2;

   // One buffered store, already lane-aligned; wen is active-low per bit
   typedef struct packed {
      logic [LSU_WA_W-1:0] word_addr;
      logic [31:0]         data;
      logic [31:0]         wen;
   } sdb_entry_t;

   typedef enum logic [1:0] {
      SDB_IDLE  = 2'd0,
      SDB_LAZY  = 2'd1,
      SDB_FORCE = 2'd2
   } sdb_state_t;

endpackage

// File: rtl/store_align.sv
// Combinational store lane alignment: builds the active-low bit write mask
// and the lane-shifted data for SB/SH/SW. Unknown funct3 gives an all-ones
// mask so the entry drains as a harmless no-op write.
module store_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  f3,
   input  logic [31:0] data,
   output logic [31:0] wen,
   output logic [31:0] aligned
);

   // Select lane from the low address bits; SH ignores addr_lo[0]
   always_comb begin
      wen     = '1;
      aligned = '0;
      case (f3)
         F3_SB: begin
            wen     = ~(32'h0000_00FF << {addr_lo, 3'b000});
            aligned = {24'h0, data[7:0]} << {addr_lo, 3'b000};
         end
         F3_SH: begin
            wen     = ~(32'h0000_FFFF << {addr_lo[1], 4'b0000});
            aligned = {16'h0, data[15:0]} << {addr_lo[1], 4'b0000};
         end
         F3_SW: begin
            wen     = '0;
            aligned = data;
         end
         default: begin
            wen     = '1;
            aligned = '0;
         end
      endcase
   end

endmodule

// File: rtl/store_drain_buffer.sv
// Post-commit store buffer. Committed stores are queued in order and drained
// into the shared DM write port. Draining normally waits for load-free cycles
// (LAZY); it switches to draining every cycle (FORCE) when the buffer is full,
// a fence is pending, or a load hits a buffered word.
module store_drain_buffer
   import lsu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_i_valid,
   input  logic [ADDR_W-1:0] st_i_addr,
   input  logic [31:0]       st_i_data,
   input  logic [2:0]        st_i_f3,
   output logic              st_o_ready,
   input  logic              ld_req_valid,
   input  logic [ADDR_W-1:0] ld_req_addr,
   output logic              ld_grant,
   output logic              ld_conflict,
   input  logic              fence_req,
   output logic              fence_done,
   output logic              DM_w_req,
   output logic [ADDR_W-1:0] DM_w_addr,
   output logic [31:0]       DM_w_en,
   output logic [31:0]       DM_w_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH / 2);

   sdb_entry_t          ents [DEPTH];
   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;
   sdb_state_t          state;
   sdb_state_t          state_next;
   logic                enq;
   logic                drain_now;
   logic                hit;
   logic [LSU_WA_W-1:0] st_wa;
   logic [LSU_WA_W-1:0] ld_wa;
   logic [31:0]         al_wen;
   logic [31:0]         al_data;
   logic                unused_ld_lo;

   store_align u_align (
      .addr_lo (st_i_addr[1:0]),
      .f3      (st_i_f3),
      .data    (st_i_data),
      .wen     (al_wen),
      .aligned (al_data)
   );

   assign st_wa        = LSU_WA_W'(st_i_addr[ADDR_W-1:2]);
   assign ld_wa        = LSU_WA_W'(ld_req_addr[ADDR_W-1:2]);
   assign unused_ld_lo = ^ld_req_addr[1:0];

   // No bypass when full: a same-cycle dequeue does not free a slot early
   assign st_o_ready = (count != CNT_FULL);
   assign enq        = st_i_valid && st_o_ready;
   assign drain_now  = (count != '0) && ((state == SDB_FORCE) || !ld_req_valid);
   assign count_next = count + CNT_W'(enq) - CNT_W'(drain_now);

   // Word-granular match of the load against every occupied slot, head included
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((CNT_W'(i) < count) && (ents[head + PTR_W'(i)].word_addr == ld_wa)) begin
            hit = 1'b1;
         end
      end
   end

   assign ld_conflict = ld_req_valid && hit;
   // Gated by reset so the port is never granted while the buffer is held in reset
   assign ld_grant    = rst && ld_req_valid && !drain_now && !ld_conflict;
   assign fence_done  = fence_req && (count == '0);

   // DM write port: idle values whenever no drain is issued
   always_comb begin
      DM_w_req  = drain_now;
      DM_w_addr = '0;
      DM_w_en   = '1;
      DM_w_data = '0;
      if (drain_now) begin
         DM_w_addr = {ents[head].word_addr[ADDR_W-3:0], 2'b00};
         DM_w_en   = ents[head].wen;
         DM_w_data = ents[head].data;
      end
   end

   // Drain policy state machine
   always_comb begin
      state_next = state;
      case (state)
         SDB_IDLE: begin
            if (enq) state_next = SDB_LAZY;
         end
         SDB_LAZY: begin
            if (count_next == '0)
               state_next = SDB_IDLE;
            else if ((count == CNT_FULL) || fence_req || ld_conflict)
               state_next = SDB_FORCE;
         end
         SDB_FORCE: begin
            if (count_next == '0)
               state_next = SDB_IDLE;
            else if ((count_next <= CNT_HALF) && !fence_req && !ld_conflict)
               state_next = SDB_LAZY;
         end
         default: state_next = SDB_IDLE;
      endcase
   end

   // Control registers: pointers, occupancy and drain state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= SDB_IDLE;
      end else begin
         if (enq)       tail <= tail + PTR_W'(1);
         if (drain_now) head <= head + PTR_W'(1);
         count <= count_next;
         state <= state_next;
      end
   end

   // Entry payload storage; occupancy is tracked by count, so no reset needed
   always_ff @(posedge clk) begin
      if (enq) begin
         ents[tail].word_addr <= st_wa;
         ents[tail].data      <= al_data;
         ents[tail].wen       <= al_wen;
      end
   end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well clear of the rising edge.
module tb_store_drain_buffer;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_i_valid;
   logic [31:0] st_i_addr;
   logic [31:0] st_i_data;
   logic [2:0]  st_i_f3;
   logic        st_o_ready;
   logic        ld_req_valid;
   logic [31:0] ld_req_addr;
   logic        ld_grant;
   logic        ld_conflict;
   logic        fence_req;
   logic        fence_done;
   logic        DM_w_req;
   logic [31:0] DM_w_addr;
   logic [31:0] DM_w_en;
   logic [31:0] DM_w_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_drain_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_i_valid(st_i_valid), .st_i_addr(st_i_addr), .st_i_data(st_i_data),
      .st_i_f3(st_i_f3), .st_o_ready(st_o_ready),
      .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr),
      .ld_grant(ld_grant), .ld_conflict(ld_conflict),
      .fence_req(fence_req), .fence_done(fence_done),
      .DM_w_req(DM_w_req), .DM_w_addr(DM_w_addr),
      .DM_w_en(DM_w_en), .DM_w_data(DM_w_data)
   );

   task automatic test_reset();
      rst = 1'b0; st_i_valid = 0; st_i_addr = 0; st_i_data = 0; st_i_f3 = F3_SW;
      ld_req_valid = 1'b1; ld_req_addr = 32'h0000_8000; fence_req = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (st_o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", st_o_ready); end
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", DM_w_req); end
      checks++; if (DM_w_en !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_en got %h want ffffffff", DM_w_en); end
      checks++; if (DM_w_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", DM_w_addr); end
      checks++; if (DM_w_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 0", DM_w_data); end
      checks++; if (ld_grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", ld_grant); end
      checks++; if (ld_conflict !== 1'b0) begin errors++; $display("FAIL rst_conflict got %b want 0", ld_conflict); end
      @(negedge clk);
      rst = 1'b1; ld_req_valid = 1'b0;
   endtask

   task automatic test_sb_drain();
      @(negedge clk);
      st_i_valid = 1; st_i_addr = 32'h0000_1003; st_i_data = 32'h0000_55AB; st_i_f3 = F3_SB;
      @(negedge clk);
      st_i_valid = 0;
      #1;
      checks++; if (DM_w_req !== 1'b1) begin errors++; $display("FAIL sb_req got %b want 1", DM_w_req); end
      checks++; if (DM_w_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", DM_w_addr); end
      checks++; if (DM_w_en !== 32'h00FF_FFFF) begin errors++; $display("FAIL sb_en got %h want 00ffffff", DM_w_en); end
      checks++; if (DM_w_data !== 32'hAB00_0000) begin errors++; $display("FAIL sb_data got %h want ab000000", DM_w_data); end
      @(negedge clk);
      #1;
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL sb_idle_req got %b want 0", DM_w_req); end
      checks++; if (DM_w_en !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sb_idle_en got %h want ffffffff", DM_w_en); end
   endtask

   task automatic test_align();
      logic [31:0] a_addr [4] = '{32'h2002, 32'h2003, 32'h2001, 32'h2008};
      logic [2:0]  a_f3   [4] = '{F3_SH, F3_SH, F3_SB, 3'b111};
      logic [31:0] a_data [4] = '{32'h1234ABCD, 32'h1234ABCD, 32'h000000C3, 32'hDEADBEEF};
      logic [31:0] e_addr [4] = '{32'h2000, 32'h2000, 32'h2000, 32'h2008};
      logic [31:0] e_en   [4] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFF00FF, 32'hFFFFFFFF};
      logic [31:0] e_data [4] = '{32'hABCD0000, 32'hABCD0000, 32'h0000C300, 32'h0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         st_i_valid = 1; st_i_addr = a_addr[i]; st_i_f3 = a_f3[i]; st_i_data = a_data[i];
         @(negedge clk);
         st_i_valid = 0;
         #1;
         checks++; if (DM_w_req !== 1'b1) begin errors++; $display("FAIL align%0d_req got %b want 1", i, DM_w_req); end
         checks++; if (DM_w_addr !== e_addr[i]) begin errors++; $display("FAIL align%0d_addr got %h want %h", i, DM_w_addr, e_addr[i]); end
         checks++; if (DM_w_en !== e_en[i]) begin errors++; $display("FAIL align%0d_en got %h want %h", i, DM_w_en, e_en[i]); end
         if (i < 3) begin
            checks++; if (DM_w_data !== e_data[i]) begin errors++; $display("FAIL align%0d_data got %h want %h", i, DM_w_data, e_data[i]); end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_lazy_force();
      ld_req_valid = 1; ld_req_addr = 32'h2000;
      for (int i = 0; i < 4; i++) begin
         st_i_valid = 1; st_i_addr = 32'h100 + 32'(4 * i); st_i_data = 32'hA0 + 32'(i); st_i_f3 = F3_SW;
         #1;
         checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL lazy_fill%0d_req got %b want 0", i, DM_w_req); end
         checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL lazy_fill%0d_grant got %b want 1", i, ld_grant); end
         @(negedge clk);
      end
      st_i_valid = 0;
      #1;
      checks++; if (st_o_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", st_o_ready); end
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL full_req got %b want 0", DM_w_req); end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++; if (DM_w_req !== 1'b1) begin errors++; $display("FAIL force%0d_req got %b want 1", i, DM_w_req); end
         checks++; if (DM_w_addr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL force%0d_addr got %h want %h", i, DM_w_addr, 32'h100 + 32'(4 * i)); end
         checks++; if (DM_w_data !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL force%0d_data got %h want %h", i, DM_w_data, 32'hA0 + 32'(i)); end
         checks++; if (ld_grant !== 1'b0) begin errors++; $display("FAIL force%0d_grant got %b want 0", i, ld_grant); end
      end
      @(negedge clk);
      #1;
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL relazy_req got %b want 0", DM_w_req); end
      checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL relazy_grant got %b want 1", ld_grant); end
      @(negedge clk);
      ld_req_valid = 0;
      for (int i = 2; i < 4; i++) begin
         #1;
         checks++; if (DM_w_addr !== 32'h100 + 32'(4 * i) || DM_w_req !== 1'b1) begin errors++; $display("FAIL tail%0d_write got %b/%h want 1/%h", i, DM_w_req, DM_w_addr, 32'h100 + 32'(4 * i)); end
         @(negedge clk);
      end
   endtask

   task automatic test_conflict();
      ld_req_valid = 1; ld_req_addr = 32'h5000;
      st_i_valid = 1; st_i_addr = 32'h3004; st_i_data = 32'h77; st_i_f3 = F3_SW;
      #1;
      checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL cf_empty_grant got %b want 1", ld_grant); end
      @(negedge clk);
      st_i_valid = 0; ld_req_addr = 32'h3006;
      #1;
      checks++; if (ld_conflict !== 1'b1) begin errors++; $display("FAIL cf_hit got %b want 1", ld_conflict); end
      checks++; if (ld_grant !== 1'b0) begin errors++; $display("FAIL cf_grant got %b want 0", ld_grant); end
      @(negedge clk);
      #1;
      checks++; if (DM_w_req !== 1'b1 || DM_w_addr !== 32'h3004) begin errors++; $display("FAIL cf_write got %b/%h want 1/00003004", DM_w_req, DM_w_addr); end
      checks++; if (ld_conflict !== 1'b1) begin errors++; $display("FAIL cf_draining_hit got %b want 1", ld_conflict); end
      @(negedge clk);
      #1;
      checks++; if (ld_conflict !== 1'b0) begin errors++; $display("FAIL cf_clear got %b want 0", ld_conflict); end
      checks++; if (ld_grant !== 1'b1) begin errors++; $display("FAIL cf_regrant got %b want 1", ld_grant); end
      @(negedge clk);
      ld_req_valid = 0;
   endtask

   task automatic test_fence();
      ld_req_valid = 1; ld_req_addr = 32'h6000;
      for (int i = 0; i < 2; i++) begin
         st_i_valid = 1; st_i_addr = 32'h600 + 32'(4 * i); st_i_data = 32'(i); st_i_f3 = F3_SW;
         @(negedge clk);
      end
      st_i_valid = 0; ld_req_valid = 0; fence_req = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence%0d_done got %b want 0", i, fence_done); end
         checks++; if (DM_w_req !== 1'b1 || DM_w_addr !== 32'h600 + 32'(4 * i)) begin errors++; $display("FAIL fence%0d_write got %b/%h want 1/%h", i, DM_w_req, DM_w_addr, 32'h600 + 32'(4 * i)); end
         @(negedge clk);
      end
      #1;
      checks++; if (fence_done !== 1'b1) begin errors++; $display("FAIL fence_done got %b want 1", fence_done); end
      checks++; if (dut.state !== SDB_IDLE) begin errors++; $display("FAIL fence_state got %0d want %0d", dut.state, SDB_IDLE); end
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL fence_idle_req got %b want 0", DM_w_req); end
      @(negedge clk);
      fence_req = 0;
   endtask

   task automatic test_stream();
      int sent = 0;
      int wr = 0;
      int cnt = 0;
      int cyc = 0;
      logic enq;
      ld_req_addr = 32'h9000;
      while ((sent < 10 || wr < 10) && cyc < 80) begin
         st_i_valid = (sent < 10);
         st_i_addr = 32'h400 + 32'(4 * sent); st_i_data = 32'hD000 + 32'(sent); st_i_f3 = F3_SW;
         ld_req_valid = (cyc < 8) || (cyc % 2 == 0);
         #1;
         checks++; if (st_o_ready !== (cnt != 4)) begin errors++; $display("FAIL st_ready%0d got %b want %b", cyc, st_o_ready, cnt != 4); end
         if (cnt != 0 && !ld_req_valid) begin
            checks++; if (DM_w_req !== 1'b1) begin errors++; $display("FAIL st_idle_drain%0d got %b want 1", cyc, DM_w_req); end
         end
         checks++; if (ld_grant !== (ld_req_valid && !DM_w_req)) begin errors++; $display("FAIL st_grant%0d got %b want %b", cyc, ld_grant, ld_req_valid && !DM_w_req); end
         if (DM_w_req === 1'b1) begin
            checks++; if (cnt == 0 || DM_w_addr !== 32'h400 + 32'(4 * wr) || DM_w_data !== 32'hD000 + 32'(wr) || DM_w_en !== 32'h0) begin
               errors++; $display("FAIL st_write%0d got %h/%h want %h/%h", wr, DM_w_addr, DM_w_data, 32'h400 + 32'(4 * wr), 32'hD000 + 32'(wr));
            end
            wr++;
         end
         enq = st_i_valid && (cnt != 4);
         cnt = cnt + int'(enq) - int'(DM_w_req === 1'b1);
         if (enq) sent++;
         cyc++;
         @(negedge clk);
      end
      checks++; if (wr != 10 || sent != 10) begin errors++; $display("FAIL st_timeout writes %0d sent %0d want 10/10", wr, sent); end
      st_i_valid = 0; ld_req_valid = 0;
   endtask

   task automatic test_reset_mid();
      ld_req_valid = 1; ld_req_addr = 32'h7000;
      for (int i = 0; i < 4; i++) begin
         st_i_valid = 1; st_i_addr = 32'h700 + 32'(4 * i); st_i_data = 32'(i); st_i_f3 = F3_SW;
         @(negedge clk);
      end
      st_i_valid = 0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (DM_w_req !== 1'b1 || DM_w_addr !== 32'h704) begin errors++; $display("FAIL mid_force got %b/%h want 1/00000704", DM_w_req, DM_w_addr); end
      rst = 0;
      #1;
      checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b want 0", DM_w_req); end
      checks++; if (DM_w_en !== 32'hFFFF_FFFF || DM_w_addr !== 32'h0 || DM_w_data !== 32'h0) begin errors++; $display("FAIL mid_rst_port got %h/%h/%h want ffffffff/0/0", DM_w_en, DM_w_addr, DM_w_data); end
      checks++; if (ld_grant !== 1'b0 || ld_conflict !== 1'b0) begin errors++; $display("FAIL mid_rst_ld got %b/%b want 0/0", ld_grant, ld_conflict); end
      checks++; if (st_o_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", st_o_ready); end
      @(negedge clk);
      rst = 1; ld_req_valid = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (DM_w_req !== 1'b0) begin errors++; $display("FAIL post_rst%0d_req got %b want 0", i, DM_w_req); end
         @(negedge clk);
      end
      st_i_valid = 1; st_i_addr = 32'h7100; st_i_data = 32'h1; st_i_f3 = F3_SW;
      @(negedge clk);
      st_i_valid = 0;
      #1;
      checks++; if (DM_w_req !== 1'b1 || DM_w_addr !== 32'h7100 || DM_w_data !== 32'h1) begin errors++; $display("FAIL post_rst_write got %b/%h/%h want 1/00007100/1", DM_w_req, DM_w_addr, DM_w_data); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_sb_drain();
      test_align();
      test_lazy_force();
      test_conflict();
      test_fence();
      test_stream();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
